word_entry_ctrl: RTL

Sequencing controller for the letter selector. It turns a "select" button press into a one-cycle `let_sel` strobe and captures the returned `user_ascii` into a LEN-letter word buffer. Once the word is complete, it compares the word against a stored code word and reports pass, fail or lockout. It sits between the debounced button pulses and the letter selector, and drives the display/status logic.

---
 rtl/word_entry_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/word_entry_ctrl.sv
// word_entry_ctrl: turns select presses into letter-selector strobes, collects
// a LEN-letter word, compares it with CODE and reports pass, fail or lockout.
module word_entry_ctrl #(
    parameter int              LEN         = 4,
    parameter logic [LEN*7-1:0] CODE       = {7'h43, 7'h4F, 7'h44, 7'h45},
    parameter int              MAX_TRIES   = 3,
    parameter int              LOCK_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             clr,
    input  logic [6:0]       user_ascii,
    output logic             let_sel,
    output logic [LEN*7-1:0] word,
    output logic [2:0]       idx,
    output logic             busy,
    output logic             unlocked,
    output logic             fail,
    output logic             locked,
    output logic [2:0]       tries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_CHECK,
        S_FAIL,
        S_PASS,
        S_LOCK
    } state_e;

    state_e           state_q, state_d;
    logic [LEN*7-1:0] word_q, word_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       tries_q, tries_d;
    logic [31:0]      lock_cnt_q, lock_cnt_d;
    logic             let_sel_q;
    logic             fail_q;

    // Next-state and datapath decode for the entry sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tries_d    = tries_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            S_IDLE: begin
                // clr has priority; a simultaneous sel is dropped.
                if (clr) begin
                    word_d = '0;
                    idx_d  = '0;
                end else if (sel) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                // Letter 0 lives in the MSBs, so slot i sits at (LEN-1-i)*7.
                for (int i = 0; i < LEN; i++) begin
                    if (idx_q == 3'(i)) begin
                        word_d[(LEN-1-i)*7 +: 7] = user_ascii;
                    end
                end
                if (idx_q == 3'(LEN - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (word_q == CODE) begin
                    tries_d = '0;
                    state_d = S_PASS;
                end else if (tries_q + 3'd1 == 3'(MAX_TRIES)) begin
                    tries_d    = 3'(MAX_TRIES);
                    lock_cnt_d = 32'(LOCK_CYCLES - 1);
                    state_d    = S_LOCK;
                end else begin
                    tries_d = tries_q + 3'd1;
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                word_d  = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            S_PASS: begin
                if (clr) begin
                    word_d  = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                // Counter starts at LOCK_CYCLES-1 and exits on 0, giving
                // exactly LOCK_CYCLES cycles in this state.
                if (lock_cnt_q == '0) begin
                    tries_d = '0;
                    word_d  = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            tries_q    <= '0;
            lock_cnt_q <= '0;
            let_sel_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            tries_q    <= tries_d;
            lock_cnt_q <= lock_cnt_d;
            let_sel_q  <= (state_d == S_REQ);
            fail_q     <= (state_d == S_FAIL);
        end
    end

    assign let_sel  = let_sel_q;
    assign fail     = fail_q;
    assign word     = word_q;
    assign idx      = idx_q;
    assign tries    = tries_q;
    assign busy     = (state_q == S_REQ) || (state_q == S_CAP) || (state_q == S_CHECK);
    assign unlocked = (state_q == S_PASS);
    assign locked   = (state_q == S_LOCK);

endmodule
